// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: 2-flop synchroniser, per-bit debounce counter, edge pulses and change counter.
// Optional sticky change flag (chg_irq / chg_irq_clr) is present only when SW_DEBOUNCE_IRQ_EN is defined.
module sw_debounce_sync #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [CNT_W-1:0] chg_count
`ifdef SW_DEBOUNCE_IRQ_EN
  ,
  output logic             chg_irq,
  input  logic             chg_irq_clr
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;
  logic             any_accept;

  // State register: synchroniser, per-bit counters and the accepted vector.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1        <= '0;
      s2        <= '0;
      sw_stable <= '0;
      // NOTE: the counter array is only WIDTH entries of flops, so it is reset like any other register.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1        <= sw_raw;
      s2        <= s1;
      sw_stable <= sw_stable ^ accept;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Next-state: IDLE while s2 matches, COUNT while it differs, ACCEPT on the last counted cycle.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and no latch is inferred.
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != sw_stable[i]) begin
        if (cnt[i] == LAST) accept[i] = 1'b1;
        else                cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  assign any_accept = |accept;

  // Output register: pulses coincide with the cycle sw_stable first shows the new value.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_rise   <= '0;
      sw_fall   <= '0;
      chg_count <= '0;
    end else begin
      sw_rise   <= accept & s2;
      sw_fall   <= accept & ~s2;
      if (any_accept) chg_count <= chg_count + 1'b1;
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  // Set has priority over clear so an accept coinciding with a clear is never lost.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)       chg_irq <= 1'b0;
    else if (any_accept)      chg_irq <= 1'b1;
    else if (chg_irq_clr)     chg_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Scoreboard bench for sw_debounce_sync (DEBOUNCE_CYCLES=4): stimulus queues expected edge events,
// a negedge monitor pops and compares them whenever the DUT raises a rise/fall pulse.
module tb_sw_debounce_sync;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  stable;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [15:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw_raw;
  logic [3:0]  sw_stable;
  logic [3:0]  sw_rise;
  logic [3:0]  sw_fall;
  logic [15:0] chg_count;
`ifdef SW_DEBOUNCE_IRQ_EN
  logic        chg_irq;
  logic        chg_irq_clr;
`endif

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b1;
  exp_t        sb[$];
  exp_t        got;

  sw_debounce_sync #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sw_raw        (sw_raw),
    .sw_stable     (sw_stable),
    .sw_rise       (sw_rise),
    .sw_fall       (sw_fall),
    .chg_count     (chg_count)
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    .chg_irq       (chg_irq),
    .chg_irq_clr   (chg_irq_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge: drive v and expect the accept 6 edges later with hand-computed values.
  task automatic apply(input logic [3:0] v, input logic [3:0] r, input logic [3:0] f,
                       input logic [15:0] c);
    exp_t e;
    sw_raw   = v;
    e.cyc    = cyc + 6;
    e.stable = v;
    e.rise   = r;
    e.fall   = f;
    e.count  = c;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation, including its edge.
  always @(negedge clk) begin
    if (mon_en && (sw_rise != 4'h0 || sw_fall != 4'h0)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", {24'h0, sw_rise, sw_fall}, 32'h0);
      end else begin
        got = sb.pop_front();
        check("sb_edge",   cyc,       got.cyc);
        check("sb_stable", sw_stable, got.stable);
        check("sb_rise",   sw_rise,   got.rise);
        check("sb_fall",   sw_fall,   got.fall);
        check("sb_count",  chg_count, got.count);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    sw_raw = 4'hF;
`ifdef SW_DEBOUNCE_IRQ_EN
    chg_irq_clr = 1'b0;
`endif

    // Reset held 3 edges with all switches high; outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_stable", sw_stable, 4'h0);
      check("rst_count",  chg_count, 16'h0);
      check("rst_pulses", {sw_rise, sw_fall}, 8'h0);
`ifdef SW_DEBOUNCE_IRQ_EN
      check("rst_irq", chg_irq, 1'b0);
`endif
    end
    rst_n = 1'b1;
    apply(4'hF, 4'hF, 4'h0, 16'd1);
    wait_neg(7);
    check("t1_rise_one_cycle", sw_rise, 4'h0);
    check("t1_stable_held",    sw_stable, 4'hF);

    apply(4'h0, 4'h0, 4'hF, 16'd2);
    wait_neg(8);

    // Glitch: bit0 high for 3 cycles is one short of acceptance.
    sw_raw[0] = 1'b1;
    wait_neg(3);
    sw_raw[0] = 1'b0;
    wait_neg(8);
    check("t2_glitch_stable", sw_stable, 4'h0);
    check("t2_glitch_count",  chg_count, 16'd2);

    // Bounce on bit2 every 2 cycles, final level 1 held.
    for (int k = 0; k < 4; k++) begin
      sw_raw[2] = (k % 2 == 0);
      wait_neg(2);
    end
    apply(4'b0100, 4'b0100, 4'h0, 16'd3);
    wait_neg(8);

    // Reset while bit0 has counted to 2; the count must start over.
    sw_raw = 4'b0101;
    wait_neg(4);
    rst_n = 1'b0;
    wait_neg(1);
    check("t5_rst_stable", sw_stable, 4'h0);
    check("t5_rst_count",  chg_count, 16'h0);
    wait_neg(1);
    rst_n = 1'b1;
    apply(4'b0101, 4'b0101, 4'h0, 16'd1);
    wait_neg(5);
    check("t5_no_early_accept", sw_stable, 4'h0);
    wait_neg(3);

    // Bits 1 and 3 fall together from 4'hF.
    apply(4'hF, 4'b1010, 4'h0, 16'd2);
    wait_neg(8);
    apply(4'b0101, 4'h0, 4'b1010, 16'd3);
    wait_neg(8);
    check("t4_count", chg_count, 16'd3);

`ifdef SW_DEBOUNCE_IRQ_EN
    check("irq_sticky", chg_irq, 1'b1);
    chg_irq_clr = 1'b1;
    wait_neg(1);
    chg_irq_clr = 1'b0;
    check("irq_clr_alone", chg_irq, 1'b0);
    apply(4'hF, 4'b1010, 4'h0, 16'd4);
    wait_neg(5);
    check("irq_before_accept", chg_irq, 1'b0);
    wait_neg(1);
    check("irq_set", chg_irq, 1'b1);
    wait_neg(2);
    apply(4'b0101, 4'h0, 4'b1010, 16'd5);
    wait_neg(5);
    chg_irq_clr = 1'b1;
    wait_neg(1);
    chg_irq_clr = 1'b0;
    check("irq_set_wins", chg_irq, 1'b1);
    wait_neg(1);
    chg_irq_clr = 1'b1;
    wait_neg(1);
    chg_irq_clr = 1'b0;
    check("irq_clr_after", chg_irq, 1'b0);
    wait_neg(4);
`endif

    // Wrap: stagger bit toggles so exactly one bit is accepted every cycle.
    mon_en = 1'b0;
    sw_raw = 4'h0;
    rst_n  = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);
    check("t6_count_start", chg_count, 16'h0);
    for (int j = 0; j < 65535; j++) begin
      sw_raw[j % 4] = ~sw_raw[j % 4];
      @(negedge clk);
    end
    wait_neg(10);
    check("t6_count_max", chg_count, 16'hFFFF);
    sw_raw[0] = ~sw_raw[0];
    wait_neg(8);
    check("t6_count_wrap", chg_count, 16'h0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
